// File: rtl/rst_release_seq.sv
// Reset release sequencer. It synchronizes raw reset deassertion, holds for HOLD_CYCLES, then
// releases NUM_OUTS domains in index order. Define RST_SEQ_WDOG_EN to add the heartbeat watchdog.
module rst_release_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUTS    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_rst_req,
`ifdef RST_SEQ_WDOG_EN
  input  logic                heartbeat,
  output logic                wdog_fired,
`endif
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                all_released,
  output logic [1:0]          seq_state,
  output logic [7:0]          reset_count
);

  localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_ALL = (MAX_HG > WDOG_CYCLES) ? MAX_HG : WDOG_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_OUTS-1:0]   rst_out_q, rst_out_d;
  logic                  all_rel_q, all_rel_d;
  logic [7:0]            rcount_q, rcount_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [NUM_OUTS-1:0]   rst_shift;
  logic                  rst_sync;
  logic                  reseq;

  // A zero enters at bit 0 each edge; the top flop is the synchronized reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync  = sync_q[SYNC_STAGES-1];
  assign rst_shift = rst_out_q << 1;

`ifdef RST_SEQ_WDOG_EN
  logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_fired_q, wdog_fired_d;
  logic          wdog_trip;

  always_comb begin
    wdog_cnt_d   = '0;
    wdog_fired_d = wdog_fired_q;
    wdog_trip    = 1'b0;
    if (state_q == ST_RUN) begin
      if (heartbeat) begin
        wdog_cnt_d = '0;
      end else if (wdog_cnt_q == CW'(WDOG_CYCLES - 1)) begin
        wdog_trip    = 1'b1;
        wdog_fired_d = 1'b1;
      end else begin
        wdog_cnt_d = wdog_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_q   <= '0;
      wdog_fired_q <= 1'b0;
    end else begin
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_fired_q <= wdog_fired_d;
    end
  end

  assign reseq      = sw_rst_req | wdog_trip;
  assign wdog_fired = wdog_fired_q;
`else
  assign reseq = sw_rst_req;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    all_rel_d = all_rel_q;
    rcount_d  = rcount_q;
    unique case (state_q)
      ST_ASSERT: begin
        if (!rst_sync) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (reseq) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          rst_out_d = rst_shift;
          cnt_d     = '0;
          if (rst_shift == '0) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (reseq) begin
          rst_out_d = '1;
          all_rel_d = 1'b0;
          state_d   = ST_HOLD;
          cnt_d     = '0;
          if (rcount_q != 8'hFF) rcount_d = rcount_q + 8'd1;
        end else if (state_q == ST_RELEASE) begin
          // Bits fall in index order by shifting zeros in from bit 0.
          if (cnt_q == GAP_LAST) begin
            rst_out_d = rst_shift;
            cnt_d     = '0;
            if (rst_shift == '0) begin
              state_d   = ST_RUN;
              all_rel_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      rst_out_q <= '1;
      all_rel_q <= 1'b0;
      rcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      all_rel_q <= all_rel_d;
      rcount_q  <= rcount_d;
    end
  end

  assign rst_out      = rst_out_q;
  assign all_released = all_rel_q;
  assign seq_state    = state_q;
  assign reset_count  = rcount_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// Scoreboard bench for rst_release_seq: default instance, a short single-output variant and,
// with RST_SEQ_WDOG_EN, a fast-watchdog variant.
module tb_rst_release_seq;

  typedef struct {
    logic [15:0] v;
    string       name;
  } exp_t;

  localparam logic [15:0] ASSERT_V = {1'b0, 4'hF, 1'b0, 2'd0, 8'd0};

  logic       clk;
  logic       reset, sw_rst_req;
  logic [3:0] rst_out_m;
  logic       all_m;
  logic [1:0] st_m;
  logic [7:0] rc_m;

  logic       reset_s, req_s;
  logic [0:0] rst_out_s;
  logic       all_s;
  logic [1:0] st_s;
  logic [7:0] rc_s;

  logic [15:0] obs_main, obs_small;
  exp_t        sb[$];
  int          tests_run;
  int          tests_failed;

  assign obs_main  = {1'b0, rst_out_m, all_m, st_m, rc_m};
  assign obs_small = {4'b0, rst_out_s, all_s, st_s, rc_s};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  rst_release_seq u_main (
    .clk          (clk),
    .reset        (reset),
    .sw_rst_req   (sw_rst_req),
`ifdef RST_SEQ_WDOG_EN
    .heartbeat    (1'b1),
    .wdog_fired   (),
`endif
    .rst_out      (rst_out_m),
    .all_released (all_m),
    .seq_state    (st_m),
    .reset_count  (rc_m)
  );

  rst_release_seq #(.SYNC_STAGES(3), .NUM_OUTS(1), .HOLD_CYCLES(1)) u_small (
    .clk          (clk),
    .reset        (reset_s),
    .sw_rst_req   (req_s),
`ifdef RST_SEQ_WDOG_EN
    .heartbeat    (1'b1),
    .wdog_fired   (),
`endif
    .rst_out      (rst_out_s),
    .all_released (all_s),
    .seq_state    (st_s),
    .reset_count  (rc_s)
  );

  // Expected outputs of a default-parameter instance k edges after entering HOLD.
  function automatic logic [15:0] seq_exp(int k, logic [7:0] rc);
    int         rel;
    logic [3:0] r;
    logic [1:0] st;
    rel = (k < 16) ? 0 : 1 + (k - 16) / 4;
    if (rel > 4) rel = 4;
    r  = 4'hF << rel;
    st = (k < 16) ? 2'd1 : ((rel < 4) ? 2'd2 : 2'd3);
    return {1'b0, r, (rel == 4), st, rc};
  endfunction

  task automatic test_reset();
    exp_t e;
    #1;
    tests_run++;
    if (obs_main !== ASSERT_V) begin
      tests_failed++;
      $display("FAIL reset_async: got %h want %h", obs_main, ASSERT_V);
    end
    #35;
    reset = 1'b0;
    for (int n = 0; n < 35; n++) begin
      e.v    = (n < 2) ? ASSERT_V : seq_exp(n - 2, 8'd0);
      e.name = $sformatf("t1_E%0d", n);
      sb.push_back(e);
    end
    for (int n = 0; n < 35; n++) begin
      @(posedge clk); #1;
      if (n == 1) sw_rst_req = 1'b0;
      e = sb.pop_front();
      tests_run++;
      if (obs_main !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_main, e.v);
      end
    end
  endtask

  task automatic test_sw_req();
    exp_t e;
    sw_rst_req = 1'b1;
    for (int j = 0; j < 33; j++) begin
      e.v    = seq_exp(j, 8'd1);
      e.name = $sformatf("sw_req_S+%0d", j);
      sb.push_back(e);
    end
    for (int j = 0; j < 33; j++) begin
      @(posedge clk); #1;
      if (j == 0) sw_rst_req = 1'b0;
      e = sb.pop_front();
      tests_run++;
      if (obs_main !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_main, e.v);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    int   rc;
    sw_rst_req = 1'b1;
    for (int j = 0; j < 300; j++) begin
      e.v    = seq_exp(0, 8'd2);
      e.name = $sformatf("held_req_%0d", j);
      sb.push_back(e);
    end
    for (int j = 0; j < 300; j++) begin
      @(posedge clk); #1;
      if (j == 299) sw_rst_req = 1'b0;
      e = sb.pop_front();
      tests_run++;
      if (obs_main !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_main, e.v);
      end
    end
    rc = 2;
    for (int i = 0; i < 258; i++) begin
      repeat (15) @(posedge clk);
      e.v    = seq_exp(16, 8'(rc));
      e.name = $sformatf("resq_rel_%0d", i);
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (obs_main !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_main, e.v);
      end
      sw_rst_req = 1'b1;
      rc = (rc < 255) ? rc + 1 : 255;
      e.v    = seq_exp(0, 8'(rc));
      e.name = $sformatf("resq_cnt_%0d", i);
      sb.push_back(e);
      @(posedge clk); #1;
      sw_rst_req = 1'b0;
      e = sb.pop_front();
      tests_run++;
      if (obs_main !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_main, e.v);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (obs_main !== ASSERT_V) begin
      tests_failed++;
      $display("FAIL sat_then_reset: got %h want %h", obs_main, ASSERT_V);
    end
    #3 reset = 1'b0;
    for (int n = 0; n < 25; n++) begin
      e.v    = (n < 2) ? ASSERT_V : seq_exp(n - 2, 8'd0);
      e.name = $sformatf("mid_pre_E%0d", n);
      sb.push_back(e);
    end
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (obs_main !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_main, e.v);
      end
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (obs_main !== ASSERT_V) begin
      tests_failed++;
      $display("FAIL mid_release_async: got %h want %h", obs_main, ASSERT_V);
    end
    #2 reset = 1'b0;
    for (int n = 0; n < 33; n++) begin
      e.v    = (n < 2) ? ASSERT_V : seq_exp(n - 2, 8'd0);
      e.name = $sformatf("mid_post_E%0d", n);
      sb.push_back(e);
    end
    for (int n = 0; n < 33; n++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (obs_main !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_main, e.v);
      end
    end
  endtask

  task automatic test_small();
    exp_t e;
    logic [15:0] sv [8];
    sv[0] = {4'b0, 1'b1, 1'b0, 2'd0, 8'd0};
    sv[1] = sv[0];
    sv[2] = sv[0];
    sv[3] = {4'b0, 1'b1, 1'b0, 2'd1, 8'd0};
    sv[4] = {4'b0, 1'b0, 1'b1, 2'd3, 8'd0};
    sv[5] = sv[4];
    sv[6] = {4'b0, 1'b1, 1'b0, 2'd1, 8'd1};
    sv[7] = {4'b0, 1'b0, 1'b1, 2'd3, 8'd1};
    tests_run++;
    if (obs_small !== sv[0]) begin
      tests_failed++;
      $display("FAIL small_reset: got %h want %h", obs_small, sv[0]);
    end
    reset_s = 1'b0;
    for (int n = 0; n < 8; n++) begin
      e.v    = sv[n];
      e.name = $sformatf("small_E%0d", n);
      sb.push_back(e);
    end
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      req_s = (n == 5);
      e = sb.pop_front();
      tests_run++;
      if (obs_small !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_small, e.v);
      end
    end
  endtask

`ifdef RST_SEQ_WDOG_EN
  logic       reset_w, hb_w;
  logic [3:0] rst_out_w;
  logic       all_w, fired_w;
  logic [1:0] st_w;
  logic [7:0] rc_w;
  logic [15:0] obs_wd;

  assign obs_wd = {fired_w, rst_out_w, all_w, st_w, rc_w};

  rst_release_seq #(.WDOG_CYCLES(8)) u_wd (
    .clk          (clk),
    .reset        (reset_w),
    .sw_rst_req   (1'b0),
    .heartbeat    (hb_w),
    .wdog_fired   (fired_w),
    .rst_out      (rst_out_w),
    .all_released (all_w),
    .seq_state    (st_w),
    .reset_count  (rc_w)
  );

  task automatic test_wdog();
    exp_t e;
    hb_w    = 1'b0;
    reset_w = 1'b0;
    for (int n = 0; n < 39; n++) begin
      e.v    = (n < 2) ? ASSERT_V : ((n < 38) ? seq_exp(n - 2, 8'd0) : (seq_exp(0, 8'd1) | 16'h8000));
      e.name = $sformatf("wdog_E%0d", n);
      sb.push_back(e);
    end
    for (int n = 0; n < 39; n++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (obs_wd !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_wd, e.v);
      end
    end
    for (int j = 1; j <= 1030; j++) begin
      e.v    = seq_exp(j, 8'd1) | 16'h8000;
      e.name = $sformatf("wdog_hb_%0d", j);
      sb.push_back(e);
    end
    for (int j = 1; j <= 1030; j++) begin
      hb_w = (j % 5 == 0);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (obs_wd !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %h want %h", e.name, obs_wd, e.v);
      end
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    reset_s      = 1'b0;
    sw_rst_req   = 1'b1;
    req_s        = 1'b0;
`ifdef RST_SEQ_WDOG_EN
    reset_w      = 1'b0;
    hb_w         = 1'b0;
`endif
    #1;
    reset   = 1'b1;
    reset_s = 1'b1;
`ifdef RST_SEQ_WDOG_EN
    reset_w = 1'b1;
`endif
    test_reset();
    test_sw_req();
    test_saturate();
    test_mid_reset();
    test_small();
`ifdef RST_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
